// File: rtl/seq_add_sub.sv
// Multi-cycle adder/subtractor: CHUNK bits per cycle, result N=WIDTH/CHUNK edges after accept, held until out_ready.
// Optional ADD_SUB_SAT_EN: signed saturation of s on overflow, applied on the edge that enters DONE.
module seq_add_sub #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             sub,
   input  logic             cin,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);

   localparam int N  = WIDTH / CHUNK;
   localparam int KW = (N > 1) ? $clog2(N) : 1;

   generate
      if (WIDTH % CHUNK != 0) begin : g_bad_chunk
         $error("seq_add_sub: WIDTH must be a multiple of CHUNK");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] xa, yb;
   logic             carry;
   logic [KW-1:0]    k;

   logic [WIDTH-1:0] xa_sh, yb_sh, mask, s_next;
   logic [CHUNK-1:0] xa_c, yb_c, sum_c;
   logic             c_out_c, msb_cin, ovf_c, last, accept;
   int               shamt;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid && (state == IDLE);
   assign last      = (k == KW'(N - 1));

   // Chunk slice by shifting rather than a variable part-select.
   always_comb begin
      shamt = int'(k) * CHUNK;
      xa_sh = xa >> shamt;
      yb_sh = yb >> shamt;
      xa_c  = xa_sh[CHUNK-1:0];
      yb_c  = yb_sh[CHUNK-1:0];
      {c_out_c, sum_c} = {1'b0, xa_c} + {1'b0, yb_c} + {{CHUNK{1'b0}}, carry};
      // Carry into the top bit of this chunk; only meaningful on the last chunk.
      msb_cin = xa_c[CHUNK-1] ^ yb_c[CHUNK-1] ^ sum_c[CHUNK-1];
      ovf_c   = msb_cin ^ c_out_c;
      mask    = WIDTH'({CHUNK{1'b1}}) << shamt;
      s_next  = (s & ~mask) | ((WIDTH'(sum_c)) << shamt);
   end

`ifdef ADD_SUB_SAT_EN
   logic [WIDTH-1:0] sat_val;
   assign sat_val = xa[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid) state_next = RUN;
         RUN:     if (last) state_next = DONE;
         DONE:    if (out_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         xa    <= '0;
         yb    <= '0;
         carry <= 1'b0;
         k     <= '0;
         s     <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         state <= state_next;
         if (accept) begin
            xa    <= x;
            yb    <= sub ? ~y : y;
            // Subtract is x + ~y + 1 - borrow, so the initial carry is the inverted borrow.
            carry <= cin ^ sub;
            k     <= '0;
         end else if (state == RUN) begin
            carry <= c_out_c;
            k     <= k + 1'b1;
            s     <= s_next;
            if (last) begin
               cout <= c_out_c;
               ovf  <= ovf_c;
`ifdef ADD_SUB_SAT_EN
               if (ovf_c) s <= sat_val;
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_seq_add_sub.sv
// Bench for seq_add_sub: three instances (CHUNK 8, 32, 1) checked against a full-width scoreboard model.
module tb_seq_add_sub;

   typedef struct packed {
      logic [31:0] s;
      logic        cout;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        iv [3];
   logic        orr[3];
   logic        sb [3];
   logic        ci [3];
   logic [31:0] xv [3];
   logic [31:0] yv [3];
   logic        ir [3];
   logic        ov [3];
   logic        co [3];
   logic        of [3];
   logic [31:0] sv [3];

   int   nchunk[3] = '{4, 1, 32};
   exp_t q[$];
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   seq_add_sub #(.WIDTH(32), .CHUNK(8)) dut0 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .sub(sb[0]), .cin(ci[0]),
      .x(xv[0]), .y(yv[0]), .out_valid(ov[0]), .out_ready(orr[0]), .s(sv[0]), .cout(co[0]), .ovf(of[0]));
   seq_add_sub #(.WIDTH(32), .CHUNK(32)) dut1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .sub(sb[1]), .cin(ci[1]),
      .x(xv[1]), .y(yv[1]), .out_valid(ov[1]), .out_ready(orr[1]), .s(sv[1]), .cout(co[1]), .ovf(of[1]));
   seq_add_sub #(.WIDTH(32), .CHUNK(1)) dut2 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .sub(sb[2]), .cin(ci[2]),
      .x(xv[2]), .y(yv[2]), .out_valid(ov[2]), .out_ready(orr[2]), .s(sv[2]), .cout(co[2]), .ovf(of[2]));

   function automatic exp_t model(input logic b_sub, input logic b_cin, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      logic [31:0] be;
      logic [32:0] f;
      be     = b_sub ? ~b : b;
      f      = {1'b0, a} + {1'b0, be} + {32'd0, b_sub ^ b_cin};
      e.s    = f[31:0];
      e.cout = f[32];
      e.ovf  = (a[31] == be[31]) && (f[31] != a[31]);
`ifdef ADD_SUB_SAT_EN
      if (e.ovf) e.s = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
      return e;
   endfunction

   task automatic do_op(input int u, input logic b_sub, input logic b_cin, input logic [31:0] a, input logic [31:0] b);
      exp_t e;
      int   lat;
      q.push_back(model(b_sub, b_cin, a, b));
      @(negedge clk);
      sb[u] = b_sub; ci[u] = b_cin; xv[u] = a; yv[u] = b; iv[u] = 1'b1;
      checks++;
      if (ir[u] !== 1'b1) begin errors++; $display("FAIL in_ready_before_op u%0d: got %b want 1", u, ir[u]); end
      @(posedge clk); #1;
      iv[u] = 1'b0;
      lat = 0;
      while (ov[u] !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      checks++;
      if (lat != nchunk[u]) begin errors++; $display("FAIL latency u%0d: got %0d want %0d", u, lat, nchunk[u]); end
      e = q.pop_front();
      checks++;
      if (sv[u] !== e.s) begin errors++; $display("FAIL sum u%0d: got %h want %h", u, sv[u], e.s); end
      checks++;
      if (co[u] !== e.cout) begin errors++; $display("FAIL cout u%0d: got %b want %b", u, co[u], e.cout); end
      checks++;
      if (of[u] !== e.ovf) begin errors++; $display("FAIL ovf u%0d: got %b want %b", u, of[u], e.ovf); end
      @(posedge clk); #1;
      checks++;
      if (ov[u] !== 1'b0 || ir[u] !== 1'b1) begin
         errors++; $display("FAIL return_idle u%0d: out_valid=%b in_ready=%b want 0/1", u, ov[u], ir[u]);
      end
   endtask

   task automatic test_reset();
      for (int u = 0; u < 3; u++) begin
         checks++;
         if (ir[u] !== 1'b1 || ov[u] !== 1'b0 || sv[u] !== 32'd0 || co[u] !== 1'b0 || of[u] !== 1'b0) begin
            errors++;
            $display("FAIL reset u%0d: in_ready=%b out_valid=%b s=%h cout=%b ovf=%b want 1 0 0 0 0",
                     u, ir[u], ov[u], sv[u], co[u], of[u]);
         end
      end
   endtask

   task automatic test_add();
      do_op(0, 1'b0, 1'b0, 32'd1, 32'd5);
      do_op(0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
      do_op(0, 1'b0, 1'b1, 32'h00FF_00FF, 32'h0000_FF01);
   endtask

   task automatic test_sub();
      do_op(0, 1'b1, 1'b0, 32'd5, 32'd7);
      do_op(0, 1'b1, 1'b1, 32'd7, 32'd5);
      do_op(0, 1'b1, 1'b0, 32'h8000_0000, 32'd1);
   endtask

   task automatic test_overflow();
      do_op(0, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'd1);
      do_op(0, 1'b0, 1'b0, 32'h8000_0000, 32'h8000_0000);
   endtask

   task automatic test_backpressure();
      exp_t e;
      int   lat;
      logic [31:0] held;
      logic spurious;
      q.push_back(model(1'b0, 1'b0, 32'h1234, 32'h1111));
      orr[0] = 1'b0;
      @(negedge clk);
      sb[0] = 1'b0; ci[0] = 1'b0; xv[0] = 32'h1234; yv[0] = 32'h1111; iv[0] = 1'b1;
      @(posedge clk); #1;
      lat = 0;
      while (ov[0] !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      e = q.pop_front();
      held = sv[0];
      checks++;
      if (held !== e.s) begin errors++; $display("FAIL bp_sum: got %h want %h", held, e.s); end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         iv[0] = ~iv[0];
         xv[0] = $urandom;
         @(posedge clk); #1;
         checks++;
         if (ov[0] !== 1'b1 || sv[0] !== e.s || ir[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold cyc%0d: out_valid=%b s=%h in_ready=%b want 1 %h 0", i, ov[0], sv[0], ir[0], e.s);
         end
      end
      @(negedge clk);
      iv[0] = 1'b0;
      orr[0] = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (ov[0] !== 1'b0 || ir[0] !== 1'b1) begin
         errors++; $display("FAIL bp_release: out_valid=%b in_ready=%b want 0 1", ov[0], ir[0]);
      end
      spurious = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (ov[0] !== 1'b0 || ir[0] !== 1'b1) spurious = 1'b1;
      end
      checks++;
      if (spurious) begin errors++; $display("FAIL bp_single_transfer: got extra activity want idle"); end
   endtask

   task automatic test_abort();
      @(negedge clk);
      sb[0] = 1'b0; ci[0] = 1'b0; xv[0] = 32'h0FFF_FFFF; yv[0] = 32'h0F; iv[0] = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      checks++;
      if (ov[0] !== 1'b0 || sv[0] !== 32'd0 || ir[0] !== 1'b1) begin
         errors++; $display("FAIL abort: out_valid=%b s=%h in_ready=%b want 0 0 1", ov[0], sv[0], ir[0]);
      end
      @(negedge clk);
      rst = 1'b0;
      do_op(0, 1'b0, 1'b0, 32'd3, 32'd4);
   endtask

   task automatic test_back_to_back();
      int   acc[$];
      exp_t e;
      orr[0] = 1'b1;
      for (int cyc = 0; cyc < 24; cyc++) begin
         @(negedge clk);
         sb[0] = 1'b0; ci[0] = 1'b0; xv[0] = 32'h100 + 32'(cyc); yv[0] = 32'h55;
         iv[0] = (cyc < 19);
         if (ov[0] === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
               errors++; $display("FAIL b2b_unexpected_result: got s=%h want none", sv[0]);
            end else begin
               e = q.pop_front();
               if (sv[0] !== e.s || co[0] !== e.cout) begin
                  errors++; $display("FAIL b2b_result: got %h/%b want %h/%b", sv[0], co[0], e.s, e.cout);
               end
            end
         end
         if (ir[0] === 1'b1 && iv[0]) begin
            acc.push_back(cyc);
            q.push_back(model(1'b0, 1'b0, xv[0], yv[0]));
         end
      end
      iv[0] = 1'b0;
      checks++;
      if (q.size() != 0) begin errors++; $display("FAIL b2b_drain: got %0d pending want 0", q.size()); end
      checks++;
      if (acc.size() != 4) begin errors++; $display("FAIL b2b_accepts: got %0d want 4", acc.size()); end
      for (int i = 1; i < acc.size(); i++) begin
         checks++;
         if (acc[i] - acc[i-1] != 6) begin
            errors++; $display("FAIL b2b_period: got %0d want 6", acc[i] - acc[i-1]);
         end
      end
      q.delete();
   endtask

   task automatic test_chunk_sizes();
      for (int u = 1; u < 3; u++) begin
         do_op(u, 1'b0, 1'b0, 32'd1, 32'd5);
         do_op(u, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1);
         do_op(u, 1'b1, 1'b1, 32'd7, 32'd5);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 12; i++) begin
         do_op(i % 3, 1'($urandom), 1'($urandom), $urandom, $urandom);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      for (int u = 0; u < 3; u++) begin
         iv[u] = 1'b0; orr[u] = 1'b1; sb[u] = 1'b0; ci[u] = 1'b0; xv[u] = '0; yv[u] = '0;
      end
      #12;
      test_reset();
      @(negedge clk);
      rst = 1'b0;
      test_add();
      test_sub();
      test_overflow();
      test_backpressure();
      test_abort();
      test_back_to_back();
      test_chunk_sizes();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
